// File: rtl/xor_cipher_if.sv
// xor_cipher_if: serial key/message load and ciphertext stream bus for xor_cipher_stream
interface xor_cipher_if #(parameter int LANES = 1);
  logic ena;
  logic key_valid;
  logic msg_valid;
  logic [LANES-1:0] din;
  logic [LANES-1:0] dout;
  logic dout_valid;
  logic busy;
  logic done;
  logic key_ready;
  logic err;
  modport master (output ena, key_valid, msg_valid, din, input dout, dout_valid, busy, done, key_ready, err);
  modport slave (input ena, key_valid, msg_valid, din, output dout, dout_valid, busy, done, key_ready, err);
endinterface

// File: rtl/xor_cipher_stream.sv
// xor_cipher_stream: serial-in/serial-out XOR cipher, one KEY_SIZE chunk per cycle.
// Define XOR_CIPHER_CHAIN_EN to chain each chunk's key with the previous ciphertext chunk.
module xor_cipher_stream #(
  parameter int MSG_SIZE = 64,
  parameter int KEY_SIZE = 8,
  parameter int LANES = 1
) (
  input logic clk,
  input logic rst,
  xor_cipher_if.slave bus
);
  localparam int KB = KEY_SIZE / LANES;
  localparam int MB = MSG_SIZE / LANES;
  localparam int NC = MSG_SIZE / KEY_SIZE;
  localparam int KW = $clog2(KB + 1);
  localparam int MW = $clog2(MB + 1);
  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;
  state_t state;
  logic [KEY_SIZE-1:0] key, key_in, kx, ct;
  logic [MSG_SIZE-1:0] msg, msg_in, msg_rot;
  logic [KW-1:0] kcnt;
  logic [MW-1:0] mcnt, cnt;
  logic [LANES-1:0] dout;
  logic dout_valid, busy, done, key_ready, err;
  assign key_in = (key << LANES) | KEY_SIZE'(bus.din);
  assign msg_in = (msg << LANES) | MSG_SIZE'(bus.din);
  assign ct = msg[MSG_SIZE-1 -: KEY_SIZE] ^ kx;
  // ENC rotates the message left one chunk per cycle, so after NC cycles it is back in order as ciphertext
  assign msg_rot = (msg << KEY_SIZE) | MSG_SIZE'(ct);
`ifdef XOR_CIPHER_CHAIN_EN
  logic [KEY_SIZE-1:0] chain;
  assign kx = key ^ chain;
  always_ff @(posedge clk or posedge rst)
    if (rst) chain <= '0;
    else if (bus.ena) chain <= state == ENC ? ct : '0;
`else
  assign kx = key;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      key <= '0;
      msg <= '0;
      kcnt <= '0;
      mcnt <= '0;
      cnt <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      key_ready <= 1'b0;
      err <= 1'b0;
    end else if (bus.ena) begin
      if (state != IDLE && (bus.key_valid || bus.msg_valid)) err <= 1'b1;
      case (state)
        IDLE:
          if (bus.key_valid && bus.msg_valid) err <= 1'b1;
          else if (bus.key_valid) begin
            key <= key_ready ? KEY_SIZE'(bus.din) : key_in;
            kcnt <= key_ready ? KW'(1) : kcnt + 1'b1;
            key_ready <= key_ready ? KB == 1 : kcnt == KW'(KB - 1);
            mcnt <= '0;
          end else if (bus.msg_valid) begin
            if (!key_ready) err <= 1'b1;
            else begin
              msg <= msg_in;
              mcnt <= mcnt + 1'b1;
              if (mcnt == MW'(MB - 1)) begin
                state <= ENC;
                cnt <= '0;
              end
            end
          end
        ENC:
          if (cnt != MW'(NC)) begin
            msg <= msg_rot;
            cnt <= cnt + 1'b1;
            busy <= 1'b1;
          end else begin
            busy <= 1'b0;
            state <= OUT;
            dout_valid <= 1'b1;
            dout <= msg[MSG_SIZE-1 -: LANES];
            msg <= msg << LANES;
            cnt <= MW'(1);
            done <= MB == 1;
          end
        OUT:
          if (cnt != MW'(MB)) begin
            dout <= msg[MSG_SIZE-1 -: LANES];
            msg <= msg << LANES;
            cnt <= cnt + 1'b1;
            done <= cnt == MW'(MB - 1);
          end else begin
            state <= IDLE;
            dout_valid <= 1'b0;
            dout <= '0;
            done <= 1'b0;
            mcnt <= '0;
            cnt <= '0;
          end
        default: state <= IDLE;
      endcase
    end
  assign bus.dout = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.key_ready = key_ready;
  assign bus.err = err;
endmodule
